// File: rtl/channel_buffer.sv
// channel_buffer: captures one ROWSxCOLS map per channel, then streams 2x2 windows (stride 2).
// Define WINDOW_STRIDE1_EN for overlapping stride-1 windows.
module channel_buffer #(
   parameter int CH   = 32,
   parameter int ROWS = 34,
   parameter int COLS = 26,
   parameter int DW   = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          valid_in,
   input  logic [DW-1:0] data_in [0:CH-1],
   output logic [DW-1:0] channel1 [0:ROWS-1][0:COLS-1],
   output logic [DW-1:0] channel2 [0:ROWS-1][0:COLS-1],
   output logic [DW-1:0] channel3 [0:ROWS-1][0:COLS-1],
   output logic [DW-1:0] channel4 [0:ROWS-1][0:COLS-1],
   output logic [DW-1:0] channel5 [0:ROWS-1][0:COLS-1],
   output logic [DW-1:0] channel6 [0:ROWS-1][0:COLS-1],
   output logic [DW-1:0] channel7 [0:ROWS-1][0:COLS-1],
   output logic [DW-1:0] channel8 [0:ROWS-1][0:COLS-1],
   output logic [DW-1:0] channel9 [0:ROWS-1][0:COLS-1],
   output logic [DW-1:0] channel10 [0:ROWS-1][0:COLS-1],
   output logic [DW-1:0] channel11 [0:ROWS-1][0:COLS-1],
   output logic [DW-1:0] channel12 [0:ROWS-1][0:COLS-1],
   output logic [DW-1:0] channel13 [0:ROWS-1][0:COLS-1],
   output logic [DW-1:0] channel14 [0:ROWS-1][0:COLS-1],
   output logic [DW-1:0] channel15 [0:ROWS-1][0:COLS-1],
   output logic [DW-1:0] channel16 [0:ROWS-1][0:COLS-1],
   output logic [DW-1:0] channel17 [0:ROWS-1][0:COLS-1],
   output logic [DW-1:0] channel18 [0:ROWS-1][0:COLS-1],
   output logic [DW-1:0] channel19 [0:ROWS-1][0:COLS-1],
   output logic [DW-1:0] channel20 [0:ROWS-1][0:COLS-1],
   output logic [DW-1:0] channel21 [0:ROWS-1][0:COLS-1],
   output logic [DW-1:0] channel22 [0:ROWS-1][0:COLS-1],
   output logic [DW-1:0] channel23 [0:ROWS-1][0:COLS-1],
   output logic [DW-1:0] channel24 [0:ROWS-1][0:COLS-1],
   output logic [DW-1:0] channel25 [0:ROWS-1][0:COLS-1],
   output logic [DW-1:0] channel26 [0:ROWS-1][0:COLS-1],
   output logic [DW-1:0] channel27 [0:ROWS-1][0:COLS-1],
   output logic [DW-1:0] channel28 [0:ROWS-1][0:COLS-1],
   output logic [DW-1:0] channel29 [0:ROWS-1][0:COLS-1],
   output logic [DW-1:0] channel30 [0:ROWS-1][0:COLS-1],
   output logic [DW-1:0] channel31 [0:ROWS-1][0:COLS-1],
   output logic [DW-1:0] channel32 [0:ROWS-1][0:COLS-1],
   output logic [DW-1:0] data_out_1 [0:1][0:1],
   output logic [DW-1:0] data_out_2 [0:1][0:1],
   output logic [DW-1:0] data_out_3 [0:1][0:1],
   output logic [DW-1:0] data_out_4 [0:1][0:1],
   output logic [DW-1:0] data_out_5 [0:1][0:1],
   output logic [DW-1:0] data_out_6 [0:1][0:1],
   output logic [DW-1:0] data_out_7 [0:1][0:1],
   output logic [DW-1:0] data_out_8 [0:1][0:1],
   output logic [DW-1:0] data_out_9 [0:1][0:1],
   output logic [DW-1:0] data_out_10 [0:1][0:1],
   output logic [DW-1:0] data_out_11 [0:1][0:1],
   output logic [DW-1:0] data_out_12 [0:1][0:1],
   output logic [DW-1:0] data_out_13 [0:1][0:1],
   output logic [DW-1:0] data_out_14 [0:1][0:1],
   output logic [DW-1:0] data_out_15 [0:1][0:1],
   output logic [DW-1:0] data_out_16 [0:1][0:1],
   output logic [DW-1:0] data_out_17 [0:1][0:1],
   output logic [DW-1:0] data_out_18 [0:1][0:1],
   output logic [DW-1:0] data_out_19 [0:1][0:1],
   output logic [DW-1:0] data_out_20 [0:1][0:1],
   output logic [DW-1:0] data_out_21 [0:1][0:1],
   output logic [DW-1:0] data_out_22 [0:1][0:1],
   output logic [DW-1:0] data_out_23 [0:1][0:1],
   output logic [DW-1:0] data_out_24 [0:1][0:1],
   output logic [DW-1:0] data_out_25 [0:1][0:1],
   output logic [DW-1:0] data_out_26 [0:1][0:1],
   output logic [DW-1:0] data_out_27 [0:1][0:1],
   output logic [DW-1:0] data_out_28 [0:1][0:1],
   output logic [DW-1:0] data_out_29 [0:1][0:1],
   output logic [DW-1:0] data_out_30 [0:1][0:1],
   output logic [DW-1:0] data_out_31 [0:1][0:1],
   output logic [DW-1:0] data_out_32 [0:1][0:1],
   output logic [10:0]   m,
   output logic          state,
   output logic          valid_out,
   output logic          y
);
`ifdef WINDOW_STRIDE1_EN
   localparam int WC = COLS - 1;
   localparam int STEP = 1;
   localparam int NWIN = (ROWS - 1) * (COLS - 1);
`else
   localparam int WC = COLS / 2;
   localparam int STEP = 2;
   localparam int NWIN = (ROWS / 2) * (COLS / 2);
`endif
   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);
   typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;
   state_t        r_state, w_state_nxt;
   logic [10:0]   r_m, w_m_nxt;
   logic          r_valid, r_y, w_wr_en, w_last_wr, w_last_win;
   logic [RW-1:0] w_wr_row, w_r0, w_r1;
   logic [CW-1:0] w_wr_col, w_c0, w_c1;
   logic [DW-1:0] r_mem [0:CH-1][0:ROWS-1][0:COLS-1];
   logic [DW-1:0] r_win [0:CH-1][0:1][0:1];
   always_comb begin
      w_wr_row    = RW'(r_m / 11'(COLS));
      w_wr_col    = CW'(r_m % 11'(COLS));
      w_r0        = RW'(11'(STEP) * (r_m / 11'(WC)));
      w_c0        = CW'(11'(STEP) * (r_m % 11'(WC)));
      w_r1        = w_r0 + RW'(1);
      w_c1        = w_c0 + CW'(1);
      w_last_wr   = r_m == 11'(ROWS * COLS - 1);
      w_last_win  = r_m == 11'(NWIN - 1);
      w_wr_en     = r_state == FILL && valid_in;
      w_m_nxt     = (r_state == DRAIN) ? (w_last_win ? '0 : r_m + 11'd1)
                  : (valid_in ? (w_last_wr ? '0 : r_m + 11'd1) : r_m);
      w_state_nxt = (r_state == DRAIN) ? (w_last_win ? FILL : DRAIN)
                  : ((valid_in && w_last_wr) ? DRAIN : FILL);
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= FILL;
         r_m     <= '0;
         r_valid <= 1'b0;
         r_y     <= 1'b0;
         for (int k = 0; k < CH; k++) begin
            for (int i = 0; i < ROWS; i++)
               for (int j = 0; j < COLS; j++)
                  r_mem[k][i][j] <= '0;
            for (int i = 0; i < 2; i++)
               for (int j = 0; j < 2; j++)
                  r_win[k][i][j] <= '0;
         end
      end else begin
         r_state <= w_state_nxt;
         r_m     <= w_m_nxt;
         r_valid <= r_state == DRAIN;
         r_y     <= r_state == DRAIN && w_last_win;
         for (int k = 0; k < CH; k++) begin
            if (w_wr_en) r_mem[k][w_wr_row][w_wr_col] <= data_in[k];
            // windows hold their last value once the stream stops
            if (r_state == DRAIN) begin
               r_win[k][0][0] <= r_mem[k][w_r0][w_c0];
               r_win[k][0][1] <= r_mem[k][w_r0][w_c1];
               r_win[k][1][0] <= r_mem[k][w_r1][w_c0];
               r_win[k][1][1] <= r_mem[k][w_r1][w_c1];
            end
         end
      end
   end
   assign m = r_m;
   assign state = r_state;
   assign valid_out = r_valid;
   assign y = r_y;
   assign channel1 = r_mem[0];
   assign channel2 = r_mem[1];
   assign channel3 = r_mem[2];
   assign channel4 = r_mem[3];
   assign channel5 = r_mem[4];
   assign channel6 = r_mem[5];
   assign channel7 = r_mem[6];
   assign channel8 = r_mem[7];
   assign channel9 = r_mem[8];
   assign channel10 = r_mem[9];
   assign channel11 = r_mem[10];
   assign channel12 = r_mem[11];
   assign channel13 = r_mem[12];
   assign channel14 = r_mem[13];
   assign channel15 = r_mem[14];
   assign channel16 = r_mem[15];
   assign channel17 = r_mem[16];
   assign channel18 = r_mem[17];
   assign channel19 = r_mem[18];
   assign channel20 = r_mem[19];
   assign channel21 = r_mem[20];
   assign channel22 = r_mem[21];
   assign channel23 = r_mem[22];
   assign channel24 = r_mem[23];
   assign channel25 = r_mem[24];
   assign channel26 = r_mem[25];
   assign channel27 = r_mem[26];
   assign channel28 = r_mem[27];
   assign channel29 = r_mem[28];
   assign channel30 = r_mem[29];
   assign channel31 = r_mem[30];
   assign channel32 = r_mem[31];
   assign data_out_1 = r_win[0];
   assign data_out_2 = r_win[1];
   assign data_out_3 = r_win[2];
   assign data_out_4 = r_win[3];
   assign data_out_5 = r_win[4];
   assign data_out_6 = r_win[5];
   assign data_out_7 = r_win[6];
   assign data_out_8 = r_win[7];
   assign data_out_9 = r_win[8];
   assign data_out_10 = r_win[9];
   assign data_out_11 = r_win[10];
   assign data_out_12 = r_win[11];
   assign data_out_13 = r_win[12];
   assign data_out_14 = r_win[13];
   assign data_out_15 = r_win[14];
   assign data_out_16 = r_win[15];
   assign data_out_17 = r_win[16];
   assign data_out_18 = r_win[17];
   assign data_out_19 = r_win[18];
   assign data_out_20 = r_win[19];
   assign data_out_21 = r_win[20];
   assign data_out_22 = r_win[21];
   assign data_out_23 = r_win[22];
   assign data_out_24 = r_win[23];
   assign data_out_25 = r_win[24];
   assign data_out_26 = r_win[25];
   assign data_out_27 = r_win[26];
   assign data_out_28 = r_win[27];
   assign data_out_29 = r_win[28];
   assign data_out_30 = r_win[29];
   assign data_out_31 = r_win[30];
   assign data_out_32 = r_win[31];
endmodule

// File: tb/tb_channel_buffer.sv
// tb_channel_buffer: random frames against a flat-map reference model; windows scoreboarded by a monitor.
module tb_channel_buffer;
   logic clk = 1'b0, rst_n = 1'b0, valid_in = 1'b0;
   always #5 clk = ~clk;
   logic [31:0] din [0:31];
   logic [31:0] ch [0:31][0:33][0:25];
   logic [31:0] dout [0:31][0:1][0:1];
   logic [10:0] m;
   logic        state, valid_out, y;
`ifdef WINDOW_STRIDE1_EN
   localparam int NW = 825, WC = 25, ST = 1;
`else
   localparam int NW = 221, WC = 13, ST = 2;
`endif
   typedef struct packed {logic last; logic [31:0][3:0][31:0] w;} win_t;
   win_t        q[$];
   logic [31:0] mdl [0:31][0:883];
   int          checks = 0, errors = 0;

   channel_buffer dut (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(din),
      .channel1(ch[0]), .channel2(ch[1]), .channel3(ch[2]), .channel4(ch[3]),
      .channel5(ch[4]), .channel6(ch[5]), .channel7(ch[6]), .channel8(ch[7]),
      .channel9(ch[8]), .channel10(ch[9]), .channel11(ch[10]), .channel12(ch[11]),
      .channel13(ch[12]), .channel14(ch[13]), .channel15(ch[14]), .channel16(ch[15]),
      .channel17(ch[16]), .channel18(ch[17]), .channel19(ch[18]), .channel20(ch[19]),
      .channel21(ch[20]), .channel22(ch[21]), .channel23(ch[22]), .channel24(ch[23]),
      .channel25(ch[24]), .channel26(ch[25]), .channel27(ch[26]), .channel28(ch[27]),
      .channel29(ch[28]), .channel30(ch[29]), .channel31(ch[30]), .channel32(ch[31]),
      .data_out_1(dout[0]), .data_out_2(dout[1]), .data_out_3(dout[2]), .data_out_4(dout[3]),
      .data_out_5(dout[4]), .data_out_6(dout[5]), .data_out_7(dout[6]), .data_out_8(dout[7]),
      .data_out_9(dout[8]), .data_out_10(dout[9]), .data_out_11(dout[10]), .data_out_12(dout[11]),
      .data_out_13(dout[12]), .data_out_14(dout[13]), .data_out_15(dout[14]), .data_out_16(dout[15]),
      .data_out_17(dout[16]), .data_out_18(dout[17]), .data_out_19(dout[18]), .data_out_20(dout[19]),
      .data_out_21(dout[20]), .data_out_22(dout[21]), .data_out_23(dout[22]), .data_out_24(dout[23]),
      .data_out_25(dout[24]), .data_out_26(dout[25]), .data_out_27(dout[26]), .data_out_28(dout[27]),
      .data_out_29(dout[28]), .data_out_30(dout[29]), .data_out_31(dout[30]), .data_out_32(dout[31]),
      .m(m), .state(state), .valid_out(valid_out), .y(y)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin : mon
      win_t e;
      int   bad;
      if (valid_out) begin
         if (q.size() == 0) chk("unexpected_window", 32'd1, 32'd0);
         else begin
            e = q.pop_front();
            bad = 0;
            for (int k = 0; k < 32; k++)
               for (int i = 0; i < 2; i++)
                  for (int j = 0; j < 2; j++)
                     if (dout[k][i][j] !== e.w[k][2*i+j]) bad++;
            chk("window_words_wrong", bad, 0);
            chk("window_y", {31'd0, y}, {31'd0, e.last});
         end
      end
   end

   task automatic push_windows();
      win_t e;
      for (int w = 0; w < NW; w++) begin
         int r = ST * (w / WC), c = ST * (w % WC);
         for (int k = 0; k < 32; k++)
            for (int i = 0; i < 2; i++)
               for (int j = 0; j < 2; j++)
                  e.w[k][2*i+j] = mdl[k][(r + i) * 26 + c + j];
         e.last = (w == NW - 1);
         q.push_back(e);
      end
   endtask

   task automatic fill(input bit pat, input bit gaps);
      int idx = 0, bad = 0;
      bit v;
      while (idx < 884) begin
         v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         valid_in = v;
         for (int k = 0; k < 32; k++) din[k] = pat ? ((k << 16) | idx) : $urandom;
         if (v) for (int k = 0; k < 32; k++) mdl[k][idx] = din[k];
         @(posedge clk); #1;
         if (v) idx++;
         chk("fill_m", {21'd0, m}, (idx == 884) ? 0 : idx);
         chk("fill_state", {31'd0, state}, (idx == 884) ? 1 : 0);
      end
      valid_in = 1'b0;
      for (int k = 0; k < 32; k++)
         for (int i = 0; i < 884; i++)
            if (ch[k][i / 26][i % 26] !== mdl[k][i]) bad++;
      chk("map_words_wrong", bad, 0);
      push_windows();
   endtask

   task automatic drain(input int abort_at, input bit pat);
      int nv = 0, ny = 0;
      for (int n = 0; n <= NW; n++) begin
         valid_in = (n < NW) ? 1'($urandom_range(0, 1)) : 1'b0;
         for (int k = 0; k < 32; k++) din[k] = $urandom;
         @(posedge clk); #1;
         nv += int'(valid_out);
         ny += int'(y);
         if (pat && n == 0) begin
            chk("w0_ch1_00", dout[0][0][0], 32'h0);
            chk("w0_ch1_01", dout[0][0][1], 32'h1);
            chk("w0_ch1_10", dout[0][1][0], 32'h1A);
            chk("w0_ch1_11", dout[0][1][1], 32'h1B);
         end
`ifdef WINDOW_STRIDE1_EN
         if (pat && n == 1) begin
            chk("w1_ch1_00", dout[0][0][0], 32'h1);
            chk("w1_ch1_01", dout[0][0][1], 32'h2);
            chk("w1_ch1_10", dout[0][1][0], 32'h1B);
            chk("w1_ch1_11", dout[0][1][1], 32'h1C);
         end
`else
         if (pat && n == 13) chk("w13_ch32_00", dout[31][0][0], 32'h001F0034);
`endif
         if (n == abort_at) begin
            rst_n = 1'b0;
            valid_in = 1'b0;
            @(posedge clk); #1;
            q.delete();
            chk("abort_state", {31'd0, state}, 32'd0);
            chk("abort_valid", {31'd0, valid_out}, 32'd0);
            chk("abort_m", {21'd0, m}, 32'd0);
            chk("abort_y", {31'd0, y}, 32'd0);
            chk("abort_ch1", ch[0][0][0], 32'd0);
            chk("abort_dout", dout[0][0][0], 32'd0);
            rst_n = 1'b1;
            return;
         end
      end
      chk("valid_cycles", nv, NW);
      chk("y_cycles", ny, 1);
      chk("end_valid", {31'd0, valid_out}, 32'd0);
      chk("end_state", {31'd0, state}, 32'd0);
      chk("end_m", {21'd0, m}, 32'd0);
      chk("queue_left", q.size(), 32'd0);
   endtask

   initial begin
      for (int k = 0; k < 32; k++) din[k] = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", {31'd0, state}, 32'd0);
      chk("rst_m", {21'd0, m}, 32'd0);
      chk("rst_valid", {31'd0, valid_out}, 32'd0);
      chk("rst_y", {31'd0, y}, 32'd0);
      chk("rst_ch1", ch[0][0][0], 32'd0);
      chk("rst_dout", dout[0][0][0], 32'd0);
      rst_n = 1'b1;
      fill(1'b1, 1'b0);
      chk("ch5_1_3", ch[4][1][3], 32'h0004001D);
      drain(-1, 1'b1);
      fill(1'b0, 1'b1);
      drain(-1, 1'b0);
      fill(1'b1, 1'b1);
      chk("gap_ch5_1_3", ch[4][1][3], 32'h0004001D);
      drain(-1, 1'b1);
      fill(1'b0, 1'b0);
      drain(100, 1'b0);
      fill(1'b0, 1'b1);
      drain(-1, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end
endmodule
